// File: rtl/mux3.sv
// mux3: 3-input WIDTH-bit data selector with a sticky invalid-select monitor.
//
// y is purely combinational. Select code 2'b11 is invalid but still
// forwards d2, so a 10 -> 11 transition with stable d2 leaves y unchanged.
// sel_err latches any clock edge that samples s == 2'b11 and holds it until
// reset_n is asserted.
//
// Build option: define MUX3_REG_OUT_EN to make y_q a 1-cycle registered copy
// of y. With the macro undefined, y_q is a plain wire equal to y.
module mux3 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] y,
    input  logic             clk,
    input  logic             reset_n,
    output logic             sel_err,
    output logic [WIDTH-1:0] y_q
);

    // Combinational select; codes 10 and 11 both forward d2, while an
    // unknown select falls to the default and propagates X in simulation.
    always_comb begin
        case (s)
            2'b00:   y = d0;
            2'b01:   y = d1;
            2'b10:   y = d2;
            2'b11:   y = d2;
            default: y = {WIDTH{1'bx}};
        endcase
    end

    // Sticky flag: set by any edge that samples the invalid code, cleared
    // only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_err <= 1'b0;
        end else if (s == 2'b11) begin
            sel_err <= 1'b1;
        end
    end

`ifdef MUX3_REG_OUT_EN
    // Registered copy of y, one flop per bit.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_yq
        // Load y[gi] every edge; cleared asynchronously by reset.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                y_q[gi] <= 1'b0;
            end else begin
                y_q[gi] <= y[gi];
            end
        end
    end
`else
    // Unregistered build: y_q is simply y, unaffected by reset.
    assign y_q = y;
`endif

endmodule

// File: tb/tb_mux3.sv
// tb_mux3: directed and random checks of mux3 against a behavioural model.
// Honours MUX3_REG_OUT_EN to choose the expected y_q behaviour.
module tb_mux3;

    localparam int WIDTH = 32;

    logic [WIDTH-1:0] d0, d1, d2;
    logic [1:0]       s;
    logic [WIDTH-1:0] y;
    logic             clk;
    logic             reset_n;
    logic             sel_err;
    logic [WIDTH-1:0] y_q;

    int checks   = 0;
    int failures = 0;

    // Model state.
    logic             sel_exp;
    logic [WIDTH-1:0] yq_reg_exp;

    mux3 #(.WIDTH(WIDTH)) dut (
        .d0      (d0),
        .d1      (d1),
        .d2      (d2),
        .s       (s),
        .y       (y),
        .clk     (clk),
        .reset_n (reset_n),
        .sel_err (sel_err),
        .y_q     (y_q)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Reference select: index a table of the three inputs; code 3 aliases 2.
    function automatic logic [WIDTH-1:0] ref_y(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] c,
                                               input logic [1:0] sel);
        logic [WIDTH-1:0] tbl [3];
        int idx;
        tbl[0] = a;
        tbl[1] = b;
        tbl[2] = c;
        idx = (int'(sel) == 3) ? 2 : int'(sel);
        return tbl[idx];
    endfunction

    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Sticky model of "s was 3 at a clock edge", plus the registered y copy.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_exp    <= 1'b0;
            yq_reg_exp <= '0;
        end else begin
            if (s == 2'd3) sel_exp <= 1'b1;
            yq_reg_exp <= ref_y(d0, d1, d2, s);
        end
    end

    function automatic logic [WIDTH-1:0] yq_expected();
`ifdef MUX3_REG_OUT_EN
        return yq_reg_exp;
`else
        return ref_y(d0, d1, d2, s);
`endif
    endfunction

    // Per-cycle compare on the falling edge, where inputs are stable.
    always @(negedge clk) begin
        chk("cyc_y", y, ref_y(d0, d1, d2, s));
        chk("cyc_sel_err", {31'd0, sel_err}, {31'd0, sel_exp});
        chk("cyc_y_q", y_q, yq_expected());
    end

    initial begin
        reset_n = 1'b0;
        d0 = 32'd1; d1 = 32'd2; d2 = 32'd4; s = 2'b00;

        // Purely combinational checks, well away from any clock edge.
        @(negedge clk);
        #1 chk("lit_s00", y, 32'd1);
        s = 2'b01;
        #1 chk("lit_s01", y, 32'd2);
        s = 2'b10;
        #1 chk("lit_s10", y, 32'd4);
        d2 = 32'd16;
        #1 chk("lit_d2_change", y, 32'd16);
        s = 2'b11;
        #1 chk("lit_s11", y, 32'd16);

        // s==11 while in reset: reset wins.
        @(posedge clk);
        #1 chk("lit_reset_wins", {31'd0, sel_err}, 32'd0);

        // Release reset with s==11 held; next edge sets the flag.
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1 chk("lit_sel_err_set", {31'd0, sel_err}, 32'd1);

        // Flag is sticky across valid selects.
        s = 2'b00;
        repeat (5) @(posedge clk);
        #1 chk("lit_sel_err_sticky", {31'd0, sel_err}, 32'd1);
        chk("lit_y_after", y, 32'd1);

        // Asynchronous clear between edges.
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk("lit_async_clear", {31'd0, sel_err}, 32'd0);

        // Registered-output scenario.
        s = 2'b01; d1 = 32'd2;
        #1 reset_n = 1'b1;
        #1;
`ifdef MUX3_REG_OUT_EN
        chk("lit_yq_pre_edge", y_q, 32'd0);
`else
        chk("lit_yq_pre_edge", y_q, 32'd2);
`endif
        @(posedge clk);
        #1 chk("lit_yq_post_edge", y_q, 32'd2);
        reset_n = 1'b0;
        #1;
`ifdef MUX3_REG_OUT_EN
        chk("lit_yq_reset", y_q, 32'd0);
`else
        chk("lit_yq_reset", y_q, 32'd2);
`endif
        chk("lit_y_in_reset", y, 32'd2);
        @(negedge clk);
        #1 reset_n = 1'b1;

        // Random sweep: inputs change just after each falling edge.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            #1;
            d0 = $urandom;
            d1 = $urandom;
            d2 = $urandom;
            if ($urandom_range(0, 99) < 3) s = 2'b11;
            else s = 2'($urandom_range(0, 2));
            reset_n = ($urandom_range(0, 19) != 0);
            #1 chk("rnd_y", y, ref_y(d0, d1, d2, s));
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
